// File: rtl/vga_console_writer_pkg.sv
// Shared definitions for the console writer: FSM state encoding and the
// control codes recognised in the incoming byte stream.
package vga_console_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_SCROLL_RD,
        ST_SCROLL_WR,
        ST_CLEAR_ROW,
        ST_CLEAR_ALL
    } state_e;

    localparam logic [7:0] CH_NUL = 8'h00;
    localparam logic [7:0] CH_BS  = 8'h08;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_FF  = 8'h0C;
    localparam logic [7:0] CH_CR  = 8'h0D;

endpackage

// File: rtl/vga_console_writer.sv
// Terminal engine: turns a byte stream into glyph writes on text RAM port B,
// tracking the cursor and handling CR/LF/BS/FF, line wrap and scroll-up.
module vga_console_writer
    import vga_console_writer_pkg::*;
#(
    parameter int unsigned COLS  = 80,
    parameter int unsigned ROWS  = 40,
    parameter int unsigned ABITS = 12,
    parameter logic [7:0]  FILL  = 8'h20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic [ABITS-1:0] ram_addr,
    output logic [7:0]       ram_wdata,
    output logic             ram_we,
    input  logic [7:0]       ram_rdata,
    output logic [7:0]       crx,
    output logic [7:0]       cry,
    output logic             busy
);

    localparam logic [ABITS-1:0] COLS_A   = ABITS'(COLS);
    localparam logic [ABITS-1:0] COLM_A   = ABITS'(COLS - 1);
    localparam logic [ABITS-1:0] LAST_A   = ABITS'(COLS * ROWS - 1);
    localparam logic [ABITS-1:0] ROWB_A   = ABITS'((ROWS - 1) * COLS);
    localparam logic [7:0]       COL_LAST = 8'(COLS - 1);
    localparam logic [7:0]       ROW_LAST = 8'(ROWS - 1);

    state_e           state, state_nxt;
    logic [7:0]       col, row;
    logic [ABITS-1:0] cur_addr;
    logic [ABITS-1:0] cnt;
    logic [7:0]       byte_q;

    logic accept, col_last, row_last, is_bs;

    assign accept   = in_valid & in_ready;
    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);
    assign is_bs    = (byte_q == CH_BS);

    assign in_ready = (state == ST_IDLE);
    assign busy     = ~in_ready;
    assign crx      = col + 8'd1;
    assign cry      = row;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (in_data)
                        CH_NUL, CH_CR: state_nxt = ST_IDLE;
                        CH_LF:         state_nxt = row_last ? ST_SCROLL_RD : ST_IDLE;
                        CH_BS:         state_nxt = (col != 8'd0) ? ST_WRITE : ST_IDLE;
                        CH_FF:         state_nxt = ST_CLEAR_ALL;
                        default:       state_nxt = ST_WRITE;
                    endcase
                end
            end
            ST_WRITE:     state_nxt = (!is_bs && col_last && row_last) ? ST_SCROLL_RD : ST_IDLE;
            ST_SCROLL_RD: state_nxt = ST_SCROLL_WR;
            ST_SCROLL_WR: state_nxt = (cnt == LAST_A) ? ST_CLEAR_ROW : ST_SCROLL_RD;
            ST_CLEAR_ROW: state_nxt = (cnt == COLM_A) ? ST_IDLE : ST_CLEAR_ROW;
            ST_CLEAR_ALL: state_nxt = (cnt == LAST_A) ? ST_IDLE : ST_CLEAR_ALL;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // RAM port B is driven straight from the state so the glyph write lands the cycle after accept
    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        case (state)
            ST_WRITE: begin
                ram_addr  = cur_addr;
                ram_wdata = is_bs ? FILL : byte_q;
                ram_we    = 1'b1;
            end
            ST_SCROLL_RD: begin
                ram_addr = cnt;
            end
            ST_SCROLL_WR: begin
                ram_addr  = cnt - COLS_A;
                ram_wdata = ram_rdata;
                ram_we    = 1'b1;
            end
            ST_CLEAR_ROW: begin
                ram_addr  = ROWB_A + cnt;
                ram_wdata = FILL;
                ram_we    = 1'b1;
            end
            ST_CLEAR_ALL: begin
                ram_addr  = cnt;
                ram_wdata = FILL;
                ram_we    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            byte_q <= in_data;
        end
    end

    // Cursor, linear address and the scroll/clear counter. The linear address is
    // only ever stepped by +1, -1, +COLS or -col, so no multiplier is needed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col      <= '0;
            row      <= '0;
            cur_addr <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (in_data)
                            CH_CR: begin
                                col      <= '0;
                                cur_addr <= cur_addr - ABITS'(col);
                            end
                            CH_LF: begin
                                col <= '0;
                                if (row_last) begin
                                    cur_addr <= ROWB_A;
                                    cnt      <= COLS_A;
                                end else begin
                                    row      <= row + 8'd1;
                                    cur_addr <= cur_addr - ABITS'(col) + COLS_A;
                                end
                            end
                            CH_BS: begin
                                if (col != 8'd0) begin
                                    col      <= col - 8'd1;
                                    cur_addr <= cur_addr - 1'b1;
                                end
                            end
                            CH_FF: begin
                                col      <= '0;
                                row      <= '0;
                                cur_addr <= '0;
                                cnt      <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_WRITE: begin
                    if (!is_bs) begin
                        if (col_last) begin
                            col <= '0;
                            if (row_last) begin
                                cur_addr <= ROWB_A;
                                cnt      <= COLS_A;
                            end else begin
                                row      <= row + 8'd1;
                                cur_addr <= cur_addr + 1'b1;
                            end
                        end else begin
                            col      <= col + 8'd1;
                            cur_addr <= cur_addr + 1'b1;
                        end
                    end
                end
                ST_SCROLL_WR: cnt <= (cnt == LAST_A) ? '0 : cnt + 1'b1;
                ST_CLEAR_ROW: cnt <= cnt + 1'b1;
                ST_CLEAR_ALL: cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_console_writer.sv
// Scoreboard bench for vga_console_writer: expected RAM writes are queued as
// bytes are sent; a monitor pops and compares every write the DUT issues.
module tb_vga_console_writer;

    localparam int COLS = 80;
    localparam int ROWS = 40;
    localparam int ABITS = 12;
    localparam int NCELL = COLS * ROWS;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             in_ready;
    logic [ABITS-1:0] ram_addr;
    logic [7:0]       ram_wdata;
    logic             ram_we;
    logic [7:0]       ram_rdata;
    logic [7:0]       crx, cry;
    logic             busy;

    vga_console_writer #(.COLS(COLS), .ROWS(ROWS), .ABITS(ABITS), .FILL(8'h20)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .crx(crx), .cry(cry), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous read-first text RAM
    logic [7:0] ram [0:NCELL-1];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    int n_chk = 0;
    int n_pass = 0;
    logic [19:0] exp_q[$];
    logic [7:0]  scr [0:NCELL-1];
    int m_col = 0;
    int m_row = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: bound expired", name);
    endtask

    always @(negedge clk) begin
        if (reset_n && ram_we) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_write: got addr=%0d data=%0h expected none", ram_addr, ram_wdata);
            end else begin
                check("ram_write", 32'({ram_addr, ram_wdata}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic push(input int a, input logic [7:0] d);
        exp_q.push_back({12'(a), d});
        scr[a] = d;
    endtask

    task automatic model_scroll();
        for (int s = COLS; s < NCELL; s++) push(s - COLS, scr[s]);
        for (int c = 0; c < COLS; c++) push((ROWS - 1) * COLS + c, 8'h20);
    endtask

    task automatic model(input logic [7:0] b);
        case (b)
            8'h00: ;
            8'h0D: m_col = 0;
            8'h0A: begin
                m_col = 0;
                if (m_row == ROWS - 1) model_scroll(); else m_row++;
            end
            8'h08: begin
                if (m_col > 0) begin m_col--; push(m_row * COLS + m_col, 8'h20); end
            end
            8'h0C: begin
                for (int i = 0; i < NCELL; i++) push(i, 8'h20);
                m_col = 0; m_row = 0;
            end
            default: begin
                push(m_row * COLS + m_col, b);
                if (m_col == COLS - 1) begin
                    m_col = 0;
                    if (m_row == ROWS - 1) model_scroll(); else m_row++;
                end else m_col++;
            end
        endcase
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20000) begin @(negedge clk); n++; end
        if (!in_ready) fail_now("send_ready");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'hA5;
    endtask

    // Counts cycles with in_ready low following an accept
    task automatic wait_idle(output int n, output logic we_first);
        n = 0;
        @(negedge clk);
        we_first = ram_we;
        while (!in_ready && n < 20000) begin n++; @(negedge clk); end
        if (!in_ready) fail_now("wait_idle");
    endtask

    task automatic put(input logic [7:0] b, output int n, output logic we_first);
        model(b);
        send(b);
        wait_idle(n, we_first);
    endtask

    initial begin
        int n;
        logic wf;
        int bad;
        for (int i = 0; i < NCELL; i++) scr[i] = 8'h20;

        #1;
        check("reset_crx", 32'(crx), 32'd1);
        check("reset_cry", 32'(cry), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_ram_we", 32'(ram_we), 32'd0);
        check("reset_ram_addr", 32'(ram_addr), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // First glyph: write on the cycle after accept, then cursor advances
        put(8'h41, n, wf);
        check("glyph_latency_we", 32'(wf), 32'd1);
        check("glyph_busy", 32'(n), 32'd1);
        check("glyph_crx", 32'(crx), 32'd2);

        // Form feed clears every cell and homes the cursor
        put(8'h0C, n, wf);
        check("ff_busy", 32'(n), 32'd3200);
        check("ff_crx", 32'(crx), 32'd1);
        check("ff_cry", 32'(cry), 32'd0);

        // Five glyphs then BS: FILL at addr 4, cursor back to crx=5
        for (int i = 0; i < 5; i++) put(8'h61 + 8'(i), n, wf);
        check("pre_bs_crx", 32'(crx), 32'd6);
        put(8'h08, n, wf);
        check("bs_crx", 32'(crx), 32'd5);
        check("bs_ram4", 32'(ram[4]), 32'h20);

        // CR, then BS at column 0 must not write
        put(8'h0D, n, wf);
        check("cr_crx", 32'(crx), 32'd1);
        put(8'h08, n, wf);
        check("bs_col0_busy", 32'(n), 32'd0);
        check("bs_col0_crx", 32'(crx), 32'd1);
        put(8'h00, n, wf);
        check("nul_busy", 32'(n), 32'd0);

        // Full row of 'x' wraps onto row 1
        for (int i = 0; i < COLS; i++) put(8'h78, n, wf);
        check("wrap_crx", 32'(crx), 32'd1);
        check("wrap_cry", 32'(cry), 32'd1);
        check("wrap_ram79", 32'(ram[79]), 32'h78);

        // Content on row 1 and row 39, then LF at the bottom row scrolls
        put(8'h68, n, wf);
        put(8'h69, n, wf);
        for (int i = 0; i < ROWS - 2; i++) put(8'h0A, n, wf);
        check("bottom_cry", 32'(cry), 32'd39);
        check("bottom_crx", 32'(crx), 32'd1);
        put(8'h5A, n, wf);
        put(8'h0A, n, wf);
        check("scroll_busy", 32'(n), 32'd6320);
        check("scroll_cry", 32'(cry), 32'd39);
        check("scroll_crx", 32'(crx), 32'd1);
        check("scroll_row0_c0", 32'(ram[0]), 32'h68);
        check("scroll_row0_c1", 32'(ram[1]), 32'h69);
        check("scroll_row0_c2", 32'(ram[2]), 32'h20);
        check("scroll_row38", 32'(ram[3040]), 32'h5A);
        bad = 0;
        for (int c = 0; c < COLS; c++) if (ram[3120 + c] !== 8'h20) bad++;
        check("scroll_row39_blank", 32'(bad), 32'd0);

        // Glyph wrap at the bottom-right corner triggers a scroll
        for (int i = 0; i < COLS; i++) put(8'h71, n, wf);
        check("corner_busy", 32'(n), 32'd6321);
        check("corner_cry", 32'(cry), 32'd39);
        check("corner_crx", 32'(crx), 32'd1);
        check("corner_row38_first", 32'(ram[3040]), 32'h71);
        check("corner_row38_last", 32'(ram[3119]), 32'h71);
        check("corner_row39", 32'(ram[3199]), 32'h20);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a scroll aborts immediately
        model(8'h0A);
        send(8'h0A);
        repeat (100) @(negedge clk);
        check("midscroll_busy", 32'(in_ready), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_crx", 32'(crx), 32'd1);
        check("abort_cry", 32'(cry), 32'd0);
        check("abort_ram_we", 32'(ram_we), 32'd0);
        exp_q.delete();
        m_col = 0; m_row = 0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_abort_idle", 32'(in_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
